// File: rtl/serial_mag_comparator.sv
// serial_mag_comparator
//   Multi-cycle magnitude comparator. Operands are captured on start and
//   compared MSB-first, DIGIT bits per clock. Signed operands are handled by
//   flipping the sign bit at capture (offset binary), after which the
//   unsigned digit walk is reused unchanged.
//
// Ports
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset
//   start  in   request, sampled only while idle
//   a, b   in   operands, captured with start
//   busy   out  high while an operation is in flight (RUN and DONE)
//   done   out  one-cycle pulse, lt/gt/eq valid from this cycle on
//   lt/gt/eq out  registered one-hot result, held until the next done
module serial_mag_comparator #(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 1,
  parameter int SIGNED     = 0,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             gt,
  output logic             eq
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MSB_FLIP = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : '0;

  generate
    if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $fatal(1, "serial_mag_comparator: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             diff_q, diff_d;   // a difference has been recorded
  logic             agt_q, agt_d;     // direction of that first difference
  logic             lt_q, lt_d, gt_q, gt_d, eq_q, eq_d;

  // Operands shift left each RUN cycle, so the digit under test is always
  // the top DIGIT bits; no variable part-select is needed.
  logic [DIGIT-1:0] da, db;
  logic             dig_ne, fin_diff, fin_gt;

  assign da       = a_q[WIDTH-1 -: DIGIT];
  assign db       = b_q[WIDTH-1 -: DIGIT];
  assign dig_ne   = (da != db);
  // Only the first differing digit decides; later ones are ignored.
  assign fin_diff = diff_q | dig_ne;
  assign fin_gt   = diff_q ? agt_q : (da > db);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    agt_d   = agt_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a ^ MSB_FLIP;
          b_d     = b ^ MSB_FLIP;
          cnt_d   = '0;
          diff_d  = 1'b0;
          agt_d   = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d = a_q << DIGIT;
        b_d = b_q << DIGIT;
        if (dig_ne && !diff_q) begin
          diff_d = 1'b1;
          agt_d  = (da > db);
        end
        if ((EARLY_EXIT != 0 && dig_ne) || cnt_q == CW'(N - 1)) begin
          state_d = S_DONE;
          lt_d    = fin_diff & ~fin_gt;
          gt_d    = fin_diff & fin_gt;
          eq_d    = ~fin_diff;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      diff_q  <= 1'b0;
      agt_q   <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      agt_q   <= agt_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign lt   = lt_q;
  assign gt   = gt_q;
  assign eq   = eq_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Bench for serial_mag_comparator. Sixteen instances cover every combination
// of DIGIT {1,2,4,8}, SIGNED {0,1}, EARLY_EXIT {0,1}; all share the stimulus.
// Instance gi: DIGIT = 1 << gi[1:0], SIGNED = gi[2], EARLY_EXIT = gi[3].
module tb_serial_mag_comparator;
  localparam int W  = 16;
  localparam int NI = 16;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [W-1:0]  a, b;
  logic [NI-1:0] busy_v, done_v, lt_v, gt_v, eq_v;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit end_chk = 1'b0;

  typedef struct {
    logic [2:0] res;   // {lt, gt, eq}
    int         at;    // cycle count at which done must be seen
  } exp_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: direct (signed) compare for the result, first
  // differing digit of a^b for the latency.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input int dg, input int sg, input int ee, input int now);
    exp_t       e;
    logic [W-1:0] d;
    int         n, j, lat, seg;
    logic       l, g;
    d = x ^ y;
    n = W / dg;
    j = n;
    for (int k = 0; k < n; k++) begin
      seg = int'(d >> (W - (k + 1) * dg)) & ((1 << dg) - 1);
      if (j == n && seg != 0) j = k;
    end
    if (sg != 0) begin
      l = $signed(x) < $signed(y);
      g = $signed(x) > $signed(y);
    end else begin
      l = x < y;
      g = x > y;
    end
    lat   = (ee != 0 && j < n) ? j + 1 : n;
    e.res = {l, g, (x == y)};
    e.at  = now + 1 + lat;
    return e;
  endfunction

  generate
    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
      localparam int DG = 1 << (gi % 4);
      localparam int SG = (gi / 4) % 2;
      localparam int EE = (gi / 8) % 2;

      exp_t       q[$];
      exp_t       e;
      logic [2:0] last_r = 3'b000;
      bit         have   = 1'b0;

      serial_mag_comparator #(.WIDTH(W), .DIGIT(DG), .SIGNED(SG), .EARLY_EXIT(EE)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy_v[gi]),
        .done  (done_v[gi]),
        .lt    (lt_v[gi]),
        .gt    (gt_v[gi]),
        .eq    (eq_v[gi])
      );

      always @(negedge clk) begin
        if (rst) begin
          q.delete();
          have = 1'b0;
          chk($sformatf("rst_outs[%0d]", gi),
              {27'd0, busy_v[gi], done_v[gi], lt_v[gi], gt_v[gi], eq_v[gi]}, 32'd0);
        end else begin
          if (done_v[gi]) begin
            chk($sformatf("busy_at_done[%0d]", gi), busy_v[gi], 1);
            if (q.size() == 0) begin
              chk($sformatf("unexp_done[%0d]", gi), 1, 0);
            end else begin
              e = q.pop_front();
              chk($sformatf("result[%0d]", gi), {lt_v[gi], gt_v[gi], eq_v[gi]}, e.res);
              chk($sformatf("latency[%0d]", gi), cyc, e.at);
              chk($sformatf("onehot[%0d]", gi),
                  32'(lt_v[gi]) + 32'(gt_v[gi]) + 32'(eq_v[gi]), 1);
              last_r = e.res;
              have   = 1'b1;
            end
          end else begin
            chk($sformatf("hold[%0d]", gi), {lt_v[gi], gt_v[gi], eq_v[gi]},
                have ? last_r : 3'b000);
            if (!busy_v[gi] && start) q.push_back(model(a, b, DG, SG, EE, cyc));
          end
          if (end_chk) chk($sformatf("pending[%0d]", gi), q.size(), 0);
        end
      end
    end
  endgenerate

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (busy_v == '0) ok = 1'b1;
    end
    if (!ok) chk("idle_timeout", 0, 1);
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y);
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0; a = ~x; b = ~y;
    wait_idle();
  endtask

  int sel;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // DIGIT=4 early exit: difference at digit 1
    op(16'h1234, 16'h1334);
    chk("d4_lt", lt_v[10], 1);
    chk("d4_gt", gt_v[10], 0);

    op(16'hA5A5, 16'hA5A5);
    chk("eq_early", eq_v[8], 1);
    chk("eq_full", eq_v[0], 1);

    op(16'h8000, 16'h7FFF);
    chk("u_8000_gt", gt_v[0], 1);
    chk("s_8000_lt", lt_v[4], 1);

    op(16'hFFFF, 16'h0001);
    chk("s_m1_lt", lt_v[12], 1);
    chk("u_ffff_gt", gt_v[8], 1);

    // Reset mid-RUN: the in-flight operation must never produce done
    wait_idle();
    @(posedge clk); #1;
    start = 1'b1; a = 16'h00FF; b = 16'h00FE;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_busy", busy_v, 0);
    chk("rst_res", lt_v | gt_v | eq_v, 0);
    repeat (20) @(posedge clk);
    #1;
    chk("rst_no_done_res", lt_v | gt_v | eq_v, 0);

    op(16'h0102, 16'h0101);
    chk("post_rst_gt", gt_v[3], 1);

    // Random: start mostly held high with operands changing every cycle, so
    // captures happen at the first IDLE cycle and busy-time starts are ignored.
    for (int i = 0; i < 30000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 9) != 0);
      a     = 16'($urandom);
      sel   = int'($urandom_range(0, 3));
      if (sel == 0)      b = a;
      else if (sel == 1) b = a ^ (16'h0001 << $urandom_range(0, 15));
      else               b = 16'($urandom);
    end
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
    @(posedge clk); #1;
    end_chk = 1'b1;
    @(posedge clk); #1;
    end_chk = 1'b0;
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
